// File: rtl/i2s_adc_rx.sv
// I2S master-mode ADC receiver: generates ac_bclk/ac_lrclk and deserialises stereo samples onto valid/ready.
// Optional build define I2S_RX_PEAK_EN adds a windowed peak-level output for the LED bar.
module i2s_adc_rx #(
   parameter int unsigned BCLK_DIV    = 16,
   parameter int unsigned SAMPLE_BITS = 24
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   en,
   input  logic                   ac_adc_sdata,
   output logic                   ac_bclk,
   output logic                   ac_lrclk,
   output logic [SAMPLE_BITS-1:0] out_l,
   output logic [SAMPLE_BITS-1:0] out_r,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic                   overrun,
   output logic [7:0]             overrun_cnt
`ifdef I2S_RX_PEAK_EN
   ,
   output logic [7:0]             peak
`endif
);

   localparam logic [7:0] DIV_LAST  = 8'(BCLK_DIV - 1);
   localparam logic [4:0] LAST_SLOT = 5'(SAMPLE_BITS);

   logic                   sd_q;
   logic [7:0]             div_cnt_q, div_cnt_d;
   logic                   bclk_q, bclk_d;
   logic                   lrclk_q, lrclk_d;
   logic [5:0]             bit_cnt_q, bit_cnt_d;
   logic [SAMPLE_BITS-1:0] shift_q, shift_d, shift_nxt;
   logic [SAMPLE_BITS-1:0] hold_l_q, hold_l_d;
   logic                   done_q, done_d;
   logic [SAMPLE_BITS-1:0] out_l_q, out_l_d;
   logic [SAMPLE_BITS-1:0] out_r_q, out_r_d;
   logic                   out_valid_q, out_valid_d;
   logic                   overrun_q, overrun_d;
   logic [7:0]             ovr_cnt_q, ovr_cnt_d;
   logic                   tc, rise, fall;
   logic [4:0]             slot;

   assign tc        = (div_cnt_q == DIV_LAST);
   assign rise      = en & tc & ~bclk_q;
   assign fall      = en & tc & bclk_q;
   assign slot      = bit_cnt_q[4:0];
   assign shift_nxt = (shift_q << 1) | SAMPLE_BITS'(sd_q);

   // NOTE: every signal gets a default at the top of an always_comb so no latch is inferred.
   always_comb begin
      div_cnt_d = div_cnt_q;
      bclk_d    = bclk_q;
      lrclk_d   = lrclk_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      hold_l_d  = hold_l_q;
      done_d    = 1'b0;
      if (!en) begin
         div_cnt_d = '0;
         bclk_d    = 1'b0;
         lrclk_d   = 1'b0;
         bit_cnt_d = '0;
         shift_d   = '0;
         hold_l_d  = '0;
      end else begin
         if (tc) begin
            div_cnt_d = '0;
            bclk_d    = ~bclk_q;
         end else begin
            div_cnt_d = div_cnt_q + 8'd1;
         end
         if (fall) begin
            bit_cnt_d = bit_cnt_q + 6'd1;
            lrclk_d   = bit_cnt_d[5];
         end
         // Slot 0 is the I2S one-bit delay; slots past the word are padding.
         if (rise && slot != 5'd0 && slot <= LAST_SLOT) shift_d = shift_nxt;
         if (rise && slot == LAST_SLOT && !lrclk_q) hold_l_d = shift_nxt;
         if (rise && slot == LAST_SLOT && lrclk_q) done_d = 1'b1;
      end
   end

   always_comb begin
      out_l_d     = out_l_q;
      out_r_d     = out_r_q;
      out_valid_d = out_valid_q;
      overrun_d   = 1'b0;
      ovr_cnt_d   = ovr_cnt_q;
      if (done_q) begin
         if (!out_valid_q || out_ready) begin
            out_l_d     = hold_l_q;
            out_r_d     = shift_q;
            out_valid_d = 1'b1;
         end else begin
            overrun_d = 1'b1;
            if (ovr_cnt_q != 8'hFF) ovr_cnt_d = ovr_cnt_q + 8'd1;
         end
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sd_q        <= 1'b0;
         div_cnt_q   <= '0;
         bclk_q      <= 1'b0;
         lrclk_q     <= 1'b0;
         bit_cnt_q   <= '0;
         shift_q     <= '0;
         hold_l_q    <= '0;
         done_q      <= 1'b0;
         out_l_q     <= '0;
         out_r_q     <= '0;
         out_valid_q <= 1'b0;
         overrun_q   <= 1'b0;
         ovr_cnt_q   <= '0;
      end else begin
         sd_q        <= ac_adc_sdata;
         div_cnt_q   <= div_cnt_d;
         bclk_q      <= bclk_d;
         lrclk_q     <= lrclk_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         hold_l_q    <= hold_l_d;
         done_q      <= done_d;
         out_l_q     <= out_l_d;
         out_r_q     <= out_r_d;
         out_valid_q <= out_valid_d;
         overrun_q   <= overrun_d;
         ovr_cnt_q   <= ovr_cnt_d;
      end
   end

   assign ac_bclk     = bclk_q;
   assign ac_lrclk    = lrclk_q;
   assign out_l       = out_l_q;
   assign out_r       = out_r_q;
   assign out_valid   = out_valid_q;
   assign overrun     = overrun_q;
   assign overrun_cnt = ovr_cnt_q;

`ifdef I2S_RX_PEAK_EN
   localparam logic [SAMPLE_BITS-1:0] MIN_VAL = SAMPLE_BITS'(1) << (SAMPLE_BITS - 1);

   function automatic logic [SAMPLE_BITS-1:0] sat_abs(input logic [SAMPLE_BITS-1:0] v);
      if (!v[SAMPLE_BITS-1]) return v;
      if (v == MIN_VAL) return ~MIN_VAL;
      return -v;
   endfunction

   logic [7:0]             peak_q, peak_d, frame_pk;
   logic [9:0]             frame_cnt_q, frame_cnt_d;
   logic [SAMPLE_BITS-1:0] mag_l, mag_r, mag;

   assign mag_l    = sat_abs(hold_l_q);
   assign mag_r    = sat_abs(shift_q);
   assign mag      = (mag_l > mag_r) ? mag_l : mag_r;
   assign frame_pk = mag[SAMPLE_BITS-2 -: 8];

   // Dropped frames still count toward the window and the peak.
   always_comb begin
      peak_d      = peak_q;
      frame_cnt_d = frame_cnt_q;
      if (done_q) begin
         frame_cnt_d = frame_cnt_q + 10'd1;
         if (frame_cnt_q == 10'h3FF || frame_pk > peak_q) peak_d = frame_pk;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         peak_q      <= '0;
         frame_cnt_q <= '0;
      end else begin
         peak_q      <= peak_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

   assign peak = peak_q;
`endif

endmodule
